// File: rtl/bp_be_pkg.sv
// bp_be_pkg
// Shared types for the backend performance window controller.
//   bp_be_perf_window_state_e : per-core measurement phase
//   `BP_BE_PERF_WINDOW_REPORT_S(core_w, cnt_w) : packed report snapshot
//       {core, clk, instr, capped}, widths supplied by the user
// Optional feature macro used by the files importing this package:
//   BP_BE_PERF_WINDOW_CAP_EN

package bp_be_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        MEASURE = 2'd1,
        PENDING = 2'd2,
        DONE    = 2'd3
    } bp_be_perf_window_state_e;

endpackage

`ifndef BP_BE_PERF_WINDOW_REPORT_S_VH
`define BP_BE_PERF_WINDOW_REPORT_S_VH
`define BP_BE_PERF_WINDOW_REPORT_S(core_w, cnt_w) \
    struct packed { \
        logic [core_w-1:0] core; \
        logic [cnt_w-1:0]  clk; \
        logic [cnt_w-1:0]  instr; \
        logic              capped; \
    }
`endif

// File: rtl/bp_be_perf_window_core.sv
// bp_be_perf_window_core
// One core's measurement window: warmup skip, cycle/instruction counting,
// finish-edge freeze and (optionally) the cycle cap.
// Ports:
//   clk_i, reset_n_i     clock, async active-low reset
//   freeze_i             synchronous restart to WARMUP, counters cleared
//   warmup_instr_i       commits to skip before measuring
//   commit_v_i           instruction commit strobe
//   program_finish_i     finish level; rising edge closes the window
//   report_ack_i         this core's snapshot was accepted
//   max_cycles_i         cycle cap (0 = off), only with BP_BE_PERF_WINDOW_CAP_EN
//   state_o              current phase (also useful as a debug tap)
//   clk_cnt_o/instr_cnt_o measured counts (frozen once PENDING)
//   capped_o             window was closed by the cap
// Macro: BP_BE_PERF_WINDOW_CAP_EN enables the cycle cap.

module bp_be_perf_window_core
    import bp_be_pkg::*;
#(
    parameter int cnt_width_p    = 64,
    parameter int warmup_width_p = 30
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      freeze_i,
    input  logic [warmup_width_p-1:0] warmup_instr_i,
    input  logic                      commit_v_i,
    input  logic                      program_finish_i,
    input  logic                      report_ack_i,
`ifdef BP_BE_PERF_WINDOW_CAP_EN
    input  logic [cnt_width_p-1:0]    max_cycles_i,
`endif
    output bp_be_perf_window_state_e  state_o,
    output logic [cnt_width_p-1:0]    clk_cnt_o,
    output logic [cnt_width_p-1:0]    instr_cnt_o,
    output logic                      capped_o
);

    bp_be_perf_window_state_e r_state, w_state_n;
    logic [warmup_width_p-1:0] r_warmup_cnt, w_warmup_n;
    logic [cnt_width_p-1:0]    r_clk_cnt, w_clk_n;
    logic [cnt_width_p-1:0]    r_instr_cnt, w_instr_n;
    logic                      r_finish;
    logic                      w_finish_edge;
    logic [cnt_width_p-1:0]    w_clk_inc;
    logic [cnt_width_p-1:0]    w_instr_inc;
`ifdef BP_BE_PERF_WINDOW_CAP_EN
    logic                      r_capped, w_capped_n;
    logic                      w_cap_hit;
`endif

    assign w_finish_edge = program_finish_i & ~r_finish;
    assign w_clk_inc     = r_clk_cnt + cnt_width_p'(1);
    assign w_instr_inc   = r_instr_cnt + cnt_width_p'(commit_v_i);
`ifdef BP_BE_PERF_WINDOW_CAP_EN
    // The cap compares the post-increment count so the snapshot reads exactly max_cycles_i.
    assign w_cap_hit = (max_cycles_i != '0) && (w_clk_inc == max_cycles_i);
`endif

    always_comb begin
        w_state_n  = r_state;
        w_warmup_n = r_warmup_cnt;
        w_clk_n    = r_clk_cnt;
        w_instr_n  = r_instr_cnt;
`ifdef BP_BE_PERF_WINDOW_CAP_EN
        w_capped_n = r_capped;
`endif
        if (freeze_i) begin
            w_state_n  = WARMUP;
            w_warmup_n = '0;
            w_clk_n    = '0;
            w_instr_n  = '0;
`ifdef BP_BE_PERF_WINDOW_CAP_EN
            w_capped_n = 1'b0;
`endif
        end else begin
            case (r_state)
                WARMUP: begin
                    // A finish during warmup reports an empty window.
                    if (w_finish_edge) begin
                        w_state_n = PENDING;
                    end else if (r_warmup_cnt == warmup_instr_i) begin
                        w_state_n = MEASURE;
                    end else begin
                        w_warmup_n = r_warmup_cnt + warmup_width_p'(commit_v_i);
                    end
                end
                MEASURE: begin
                    // The closing cycle itself is still counted.
                    w_clk_n   = w_clk_inc;
                    w_instr_n = w_instr_inc;
                    if (w_finish_edge) begin
                        w_state_n = PENDING;
                    end
`ifdef BP_BE_PERF_WINDOW_CAP_EN
                    else if (w_cap_hit) begin
                        w_state_n  = PENDING;
                        w_capped_n = 1'b1;
                    end
`endif
                end
                PENDING: begin
                    if (report_ack_i) begin
                        w_state_n = DONE;
                    end
                end
                DONE: begin
                    w_state_n = DONE;
                end
                default: begin
                    w_state_n = WARMUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= WARMUP;
            r_warmup_cnt <= '0;
            r_clk_cnt    <= '0;
            r_instr_cnt  <= '0;
            r_finish     <= 1'b0;
`ifdef BP_BE_PERF_WINDOW_CAP_EN
            r_capped     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_warmup_cnt <= w_warmup_n;
            r_clk_cnt    <= w_clk_n;
            r_instr_cnt  <= w_instr_n;
            // Clearing on freeze lets a still-high finish level start a new window.
            r_finish     <= freeze_i ? 1'b0 : program_finish_i;
`ifdef BP_BE_PERF_WINDOW_CAP_EN
            r_capped     <= w_capped_n;
`endif
        end
    end

    assign state_o     = r_state;
    assign clk_cnt_o   = r_clk_cnt;
    assign instr_cnt_o = r_instr_cnt;
`ifdef BP_BE_PERF_WINDOW_CAP_EN
    assign capped_o    = r_capped;
`else
    assign capped_o    = 1'b0;
`endif

endmodule

// File: rtl/bp_be_perf_window_ctrl.sv
// bp_be_perf_window_ctrl
// Multi-core measurement-window controller: one bp_be_perf_window_core per
// core plus a round-robin arbiter that serializes frozen snapshots onto a
// single report port.
// Ports:
//   clk_i, reset_n_i      clock, async active-low reset
//   freeze_i              restart every core's window
//   warmup_instr_i        warmup commits per core
//   commit_v_i            per-core commit strobes
//   program_finish_i      per-core finish levels
//   max_cycles_i          cycle cap, only with BP_BE_PERF_WINDOW_CAP_EN
//   report_v_o/report_ready_i   snapshot handshake
//   report_core_o/clk_o/instr_o/capped_o  snapshot contents (0 when not valid)
//   all_done_o            every core has reported
// Macro: BP_BE_PERF_WINDOW_CAP_EN enables the cycle cap.
//
// Handshake: a snapshot transfers on a cycle where report_v_o & report_ready_i.
// Once report_v_o is raised it stays high with identical contents until that
// transfer (or a freeze); a later pending core never replaces it.

module bp_be_perf_window_ctrl
    import bp_be_pkg::*;
#(
    parameter int num_core_p     = 4,
    parameter int cnt_width_p    = 64,
    parameter int warmup_width_p = 30,
    localparam int core_w_lp     = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      freeze_i,
    input  logic [warmup_width_p-1:0] warmup_instr_i,
    input  logic [num_core_p-1:0]     commit_v_i,
    input  logic [num_core_p-1:0]     program_finish_i,
`ifdef BP_BE_PERF_WINDOW_CAP_EN
    input  logic [cnt_width_p-1:0]    max_cycles_i,
`endif
    output logic                      report_v_o,
    input  logic                      report_ready_i,
    output logic [core_w_lp-1:0]      report_core_o,
    output logic [cnt_width_p-1:0]    report_clk_o,
    output logic [cnt_width_p-1:0]    report_instr_o,
    output logic                      report_capped_o,
    output logic                      all_done_o
);

    typedef `BP_BE_PERF_WINDOW_REPORT_S(core_w_lp, cnt_width_p) report_s;

    bp_be_perf_window_state_e w_state     [num_core_p];
    logic [cnt_width_p-1:0]   w_clk_cnt   [num_core_p];
    logic [cnt_width_p-1:0]   w_instr_cnt [num_core_p];
    logic [num_core_p-1:0]    w_capped;
    logic [num_core_p-1:0]    w_pending;
    logic [num_core_p-1:0]    w_done;
    logic [num_core_p-1:0]    w_ack;

    logic [core_w_lp-1:0]     r_rr;
    logic                     r_lock;
    logic [core_w_lp-1:0]     r_lock_sel;
    logic [core_w_lp-1:0]     w_pick;
    logic [core_w_lp-1:0]     w_idx;
    logic [core_w_lp-1:0]     w_sel;
    logic [core_w_lp-1:0]     w_sel_inc;
    logic                     w_found;
    logic                     w_valid;
    logic                     w_handshake;
    report_s                  w_report;

    for (genvar k = 0; k < num_core_p; k++) begin : g_core
        bp_be_perf_window_core #(
            .cnt_width_p    (cnt_width_p),
            .warmup_width_p (warmup_width_p)
        ) u_core (
            .clk_i            (clk_i),
            .reset_n_i        (reset_n_i),
            .freeze_i         (freeze_i),
            .warmup_instr_i   (warmup_instr_i),
            .commit_v_i       (commit_v_i[k]),
            .program_finish_i (program_finish_i[k]),
            .report_ack_i     (w_ack[k]),
`ifdef BP_BE_PERF_WINDOW_CAP_EN
            .max_cycles_i     (max_cycles_i),
`endif
            .state_o          (w_state[k]),
            .clk_cnt_o        (w_clk_cnt[k]),
            .instr_cnt_o      (w_instr_cnt[k]),
            .capped_o         (w_capped[k])
        );

        assign w_pending[k] = (w_state[k] == PENDING);
        assign w_done[k]    = (w_state[k] == DONE);
        assign w_ack[k]     = w_handshake & (w_sel == core_w_lp'(k));
    end

    // First pending core at or above rr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < num_core_p; i++) begin
            w_idx = core_w_lp'((int'(r_rr) + i) % num_core_p);
            if (!w_found && w_pending[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_sel       = r_lock ? r_lock_sel : w_pick;
    assign w_valid     = r_lock | w_found;
    assign w_handshake = w_valid & report_ready_i;
    assign w_sel_inc   = (w_sel == core_w_lp'(num_core_p - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_sel <= '0;
        end else if (freeze_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_sel <= '0;
        end else begin
            if (w_handshake) begin
                r_rr <= w_sel_inc;
            end
            r_lock     <= w_valid & ~report_ready_i;
            r_lock_sel <= w_sel;
        end
    end

    // Report fields read as zero whenever no snapshot is offered.
    always_comb begin
        w_report = '0;
        if (w_valid) begin
            w_report.core   = w_sel;
            w_report.clk    = w_clk_cnt[w_sel];
            w_report.instr  = w_instr_cnt[w_sel];
            w_report.capped = w_capped[w_sel];
        end
    end

    assign report_v_o      = w_valid;
    assign report_core_o   = w_report.core;
    assign report_clk_o    = w_report.clk;
    assign report_instr_o  = w_report.instr;
    assign report_capped_o = w_report.capped;
    assign all_done_o      = &w_done;

endmodule

// File: tb/tb_bp_be_perf_window_ctrl.sv
module tb_bp_be_perf_window_ctrl;
  localparam int N  = 4;
  localparam int CW = 64;
  localparam int WW = 30;

  localparam int PH_WARM = 0;
  localparam int PH_MEAS = 1;
  localparam int PH_PEND = 2;
  localparam int PH_DONE = 3;

  // clock/reset and DUT signals
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          freeze = 1'b0;
  logic [WW-1:0] warm = '0;
  logic [N-1:0]  commit = '0;
  logic [N-1:0]  fin = '0;
  logic          ready = 1'b0;
  logic          report_v;
  logic [1:0]    report_core;
  logic [CW-1:0] report_clk;
  logic [CW-1:0] report_instr;
  logic          report_capped;
  logic          all_done;

  always #5 clk = ~clk;

  bp_be_perf_window_ctrl #(
    .num_core_p     (N),
    .cnt_width_p    (CW),
    .warmup_width_p (WW)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .freeze_i         (freeze),
    .warmup_instr_i   (warm),
    .commit_v_i       (commit),
    .program_finish_i (fin),
    .report_v_o       (report_v),
    .report_ready_i   (ready),
    .report_core_o    (report_core),
    .report_clk_o     (report_clk),
    .report_instr_o   (report_instr),
    .report_capped_o  (report_capped),
    .all_done_o       (all_done)
  );

  // reference model: phase per core, counts, rr pointer and held offer
  int          m_ph [N];
  longint      m_wc [N];
  logic [63:0] m_clk [N];
  logic [63:0] m_ins [N];
  bit          m_fr [N];
  int          m_rr;
  bit          m_lock;
  int          m_lsel;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_ph[k] = PH_WARM;
      m_wc[k] = 0;
      m_clk[k] = '0;
      m_ins[k] = '0;
      m_fr[k] = 1'b0;
    end
    m_rr = 0;
    m_lock = 1'b0;
    m_lsel = 0;
  endtask

  // Which snapshot should be on offer right now.
  task automatic model_out(output bit v, output int s);
    v = 1'b0;
    s = 0;
    if (m_lock) begin
      v = 1'b1;
      s = m_lsel;
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (!v && m_ph[c] == PH_PEND) begin
          v = 1'b1;
          s = c;
        end
      end
    end
  endtask

  task automatic model_step();
    bit v;
    int s;
    bit hs;
    bit fe;
    model_out(v, s);
    hs = v && ready;
    if (freeze) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        fe = fin[k] && !m_fr[k];
        if (m_ph[k] == PH_WARM) begin
          if (fe) begin
            m_ph[k] = PH_PEND;
            m_clk[k] = '0;
            m_ins[k] = '0;
          end else if (m_wc[k] == longint'(warm)) begin
            m_ph[k] = PH_MEAS;
          end else begin
            m_wc[k] += longint'(commit[k]);
          end
        end else if (m_ph[k] == PH_MEAS) begin
          m_clk[k] = m_clk[k] + 64'd1;
          m_ins[k] = m_ins[k] + 64'(commit[k]);
          if (fe) m_ph[k] = PH_PEND;
        end else if (m_ph[k] == PH_PEND) begin
          if (hs && s == k) m_ph[k] = PH_DONE;
        end
        m_fr[k] = fin[k];
      end
      if (hs) m_rr = (s + 1) % N;
      m_lock = v && !ready;
      m_lsel = s;
    end
  endtask

  task automatic check_outputs();
    bit v;
    int s;
    bit ad;
    model_out(v, s);
    ad = 1'b1;
    for (int k = 0; k < N; k++) if (m_ph[k] != PH_DONE) ad = 1'b0;
    check("valid", 64'(report_v), 64'(v));
    check("core", 64'(report_core), v ? 64'(s) : 64'd0);
    check("clk", report_clk, v ? m_clk[s] : 64'd0);
    check("instr", report_instr, v ? m_ins[s] : 64'd0);
    check("capped", 64'(report_capped), 64'd0);
    check("all_done", 64'(all_done), 64'(ad));
  endtask

  // driver: check current outputs, advance model with current inputs, one clock
  task automatic tick();
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] held_clk;
    model_reset();
    warm = 30'd3;
    commit = 4'b0001;
    fin = '0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_valid", 64'(report_v), 64'd0);
    check("rst_clk", report_clk, 64'd0);
    check("rst_all_done", 64'(all_done), 64'd0);
    rst_n = 1'b1;

    // single core window: warmup 3, commit every cycle
    repeat (19) tick();
    fin[0] = 1'b1;
    tick();
    check("s1_valid", 64'(report_v), 64'd1);
    check("s1_core", 64'(report_core), 64'd0);
    check("s1_clk", report_clk, 64'd16);
    check("s1_instr", report_instr, 64'd16);
    tick();
    commit = '0;

    // cores 0,2,3 finish together, rr=0
    freeze = 1'b1;
    fin = '0;
    tick();
    freeze = 1'b0;
    warm = '0;
    repeat (3) begin
      commit = N'($urandom);
      tick();
    end
    fin = 4'b1101;
    tick();
    check("s2_first", 64'(report_core), 64'd0);
    tick();
    check("s2_second", 64'(report_core), 64'd2);
    tick();
    check("s2_third", 64'(report_core), 64'd3);
    check("s2_not_done", 64'(all_done), 64'd0);
    ready = 1'b0;
    held_clk = report_clk;
    tick();
    fin[1] = 1'b1;
    repeat (4) begin
      check("s3_lock_core", 64'(report_core), 64'd3);
      check("s3_lock_clk", report_clk, held_clk);
      tick();
    end
    ready = 1'b1;
    check("s3_release", 64'(report_core), 64'd3);
    tick();
    check("s3_next", 64'(report_core), 64'd1);
    tick();
    check("s3_all_done", 64'(all_done), 64'd1);

    // finish during long warmup
    freeze = 1'b1;
    fin = '0;
    tick();
    freeze = 1'b0;
    warm = 30'd100;
    repeat (10) begin
      commit = N'($urandom);
      tick();
    end
    fin[2] = 1'b1;
    ready = 1'b0;
    tick();
    check("s4_core", 64'(report_core), 64'd2);
    check("s4_clk", report_clk, 64'd0);
    check("s4_instr", report_instr, 64'd0);
    tick();

    // freeze while pending, then a fresh window
    freeze = 1'b1;
    fin = '0;
    tick();
    freeze = 1'b0;
    check("s5_drop", 64'(report_v), 64'd0);
    warm = 30'd2;
    commit = 4'b0100;
    repeat (8) tick();
    fin[2] = 1'b1;
    tick();
    check("s5_core", 64'(report_core), 64'd2);
    check("s5_clk", report_clk, 64'd6);
    check("s5_instr", report_instr, 64'd6);
    ready = 1'b1;
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      commit = N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 30) == 0) fin[k] = ~fin[k];
      end
      freeze = ($urandom_range(0, 150) == 0) || (all_done && $urandom_range(0, 4) == 0);
      if (freeze) warm = WW'($urandom_range(0, 6));
      tick();
    end
    freeze = 1'b0;

    // async reset while a report is held
    freeze = 1'b1;
    fin = '0;
    tick();
    freeze = 1'b0;
    warm = '0;
    ready = 1'b0;
    commit = 4'b1111;
    repeat (5) tick();
    fin = 4'b0010;
    tick();
    tick();
    check("ar_pre_valid", 64'(report_v), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(report_v), 64'd0);
    check("ar_core", 64'(report_core), 64'd0);
    check("ar_clk", report_clk, 64'd0);
    check("ar_instr", report_instr, 64'd0);
    check("ar_capped", 64'(report_capped), 64'd0);
    check("ar_all_done", 64'(all_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_be_perf_window_ctrl.md
# bp_be_perf_window_ctrl

Multi-core measurement-window controller and report arbiter for backend performance statistics. Each core is sequenced through warmup and measurement phases, and its cycle and instruction counters are frozen when that core signals program finish. The frozen snapshots are then serialized onto one shared valid/ready report port in round-robin order. The block sits beside the cores in the testbench/SoC top, fed by per-core commit and finish strobes, and replaces per-core ad hoc stat printing with a single ordered stream.

## Interface
- num_core_p, 4, number of cores monitored (≥1)
- cnt_width_p, 64, width of clk/instr measurement counters
- warmup_width_p, 30, width of warmup instruction counter
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- freeze_i  in  1  synchronous restart: all cores back to warmup, counters cleared
- warmup_instr_i  in  warmup_width_p  committed instructions to skip per core before measuring
- commit_v_i  in  num_core_p  per-core instruction commit strobe
- program_finish_i  in  num_core_p  per-core finish level; rising edge ends that core's window
- max_cycles_i  in  cnt_width_p  window cap; present only with BP_BE_PERF_WINDOW_CAP_EN
- report_v_o  out  1  snapshot valid
- report_ready_i  in  1  consumer accepts snapshot
- report_core_o  out  clog2(num_core_p), min 1  core id of snapshot
- report_clk_o  out  cnt_width_p  measured cycles
- report_instr_o  out  cnt_width_p  measured committed instructions
- report_capped_o  out  1  window ended by cap (tied 0 without macro)
- all_done_o  out  1  every core reported

## Operation
- Per-core states: WARMUP, MEASURE, PENDING, DONE.
- WARMUP: warmup_cnt increments on commit_v_i[k]. The core moves to MEASURE in the cycle after warmup_cnt == warmup_instr_i, so warmup_instr_i=0 enters MEASURE one cycle after reset. A commit in the matching cycle is not counted.
- MEASURE: clk_cnt += 1 every cycle; instr_cnt += commit_v_i[k]. Both wrap modulo 2^cnt_width_p.
- Finish edge: program_finish_i[k] & ~finish_r[k], where finish_r is registered every cycle in all states. On this edge the core goes to PENDING and its counters are frozen. The finish cycle itself is counted, including any commit in that cycle.
- Finish edge during WARMUP: the core goes to PENDING with both counters at 0.
- PENDING → DONE on handshake (report_v_o & report_ready_i) with report_core_o == k. DONE is terminal until reset or freeze.
- Arbitration: round-robin over PENDING cores, searching from pointer rr upward and wrapping.
  - rr resets to 0 and becomes granted+1 (mod num_core_p) on each handshake.
  - While report_v_o & ~report_ready_i, the selected core and all report_* outputs are locked. A newly pending core never preempts a locked one.
- all_done_o = all cores in DONE.
- freeze_i: every core goes to WARMUP and clears its counters. Lock, rr and finish_r are cleared. A pending report is dropped and report_v_o deasserts next cycle. freeze_i has priority over handshake and finish edges.
- Reset values: all cores WARMUP, counters 0, rr 0, report_v_o 0, report_capped_o 0, all_done_o 0, all report data 0.

## Timing
- Finish edge sampled at posedge t → PENDING at t+1 → report_v_o earliest at t+1 (combinational from state registers).
- Single pending core, ready held high: one report per cycle. N simultaneous finishes drain in N consecutive cycles in rr order.
- Handshake at posedge t → the next core's report is valid at t+1. No bubble.

## Configuration
- BP_BE_PERF_WINDOW_CAP_EN defined:
  - max_cycles_i is present.
  - A MEASURE core whose clk_cnt reaches max_cycles_i enters PENDING with report_capped_o=1 for its snapshot.
  - If a finish edge and the cap occur in the same cycle, the finish wins and capped=0.
  - max_cycles_i=0 disables the cap.
- Undefined: the port is absent and report_capped_o is tied to 0.

## Structure
- bp_be_pkg holds:
  - bp_be_perf_window_state_e (WARMUP, MEASURE, PENDING, DONE)
  - a parameterized report struct macro {core, clk, instr, capped}
- Sub-module bp_be_perf_window_core: one per core, containing the FSM, counters, finish_r and cap logic.
- Round-robin selection with lock is implemented in the top.

## Test plan
- num_core_p=1, warmup=3, commit every cycle, finish at cycle 20 → single report with clk=16, instr=16.
- Cores 0, 2, 3 finish in the same cycle, ready=1, rr=0 → reports core 0, 2, 3 on consecutive cycles, then all_done_o=0 until core 1 finishes.
- Ready held low 5 cycles while core 1 finishes behind locked core 3 → outputs stay core 3 and unchanged; after ready, the next report is core 1.
- Finish during WARMUP with warmup=100 → report clk=0, instr=0.
- freeze_i while PENDING → report_v_o=0 next cycle; a later finish reports fresh counts.
- With BP_BE_PERF_WINDOW_CAP_EN, max_cycles_i=10, no finish → report clk=10, capped=1. Async reset asserted mid-report → all outputs 0 immediately.
